// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the UART instruction-memory boot loader.
//   state_t          : loader frame FSM states
//   rx_state_t       : UART receiver bit-phase states
//   HDR_BYTE         : frame header byte that starts (or restarts) a load
//   DEF_CLKS_PER_BIT : default bit period, 50 MHz / 115200 baud
// ---------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [7:0] HDR_BYTE         = 8'hA5;
   localparam int         DEF_CLKS_PER_BIT = 434;

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: two-flop synchroniser, bit timer, LSB-first shift
// register.
// Ports:
//   clock    in  : sole clock, rising edge
//   reset_n  in  : asynchronous active-low reset
//   rx       in  : serial input, idle high, asynchronous to clock
//   rx_byte  out : last received byte, valid with byte_vld
//   byte_vld out : one-cycle pulse, cycle after the stop-bit mid-sample
//   frm_err  out : one-cycle pulse when the stop bit samples low
// ---------------------------------------------------------------------------
module uart_rx
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_vld,
   output logic       frm_err
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   rx_state_t        state, state_nxt;
   logic             rx_p0, rx_p1, rx_p2;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             half_hit, full_hit, fall;

   // rx_p2 is only the previous synchronised value, kept for edge detection
   assign fall     = rx_p2 & ~rx_p1;
   assign half_hit = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
   assign full_hit = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= RX_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE:  if (fall) state_nxt = RX_START;
         // a start bit that has gone high again by mid-bit was a glitch
         RX_START: if (half_hit) state_nxt = rx_p1 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (full_hit && bit_idx == 3'd7) state_nxt = RX_STOP;
         RX_STOP:  if (full_hit) state_nxt = RX_IDLE;
         default:  state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_p0    <= 1'b1;
         rx_p1    <= 1'b1;
         rx_p2    <= 1'b1;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rx_byte  <= '0;
         byte_vld <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         rx_p0    <= rx;
         rx_p1    <= rx_p0;
         rx_p2    <= rx_p1;
         byte_vld <= 1'b0;
         frm_err  <= 1'b0;
         // timer restarts on every phase change and every full bit period
         if (state_nxt != state || full_hit) cnt <= '0;
         else if (state != RX_IDLE)          cnt <= cnt + 1'b1;
         if (state == RX_START) bit_idx <= '0;
         if (state == RX_DATA && full_hit) begin
            shreg   <= {rx_p1, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (state == RX_STOP && full_hit) begin
            rx_byte  <= shreg;
            byte_vld <= rx_p1;
            frm_err  <= ~rx_p1;
         end
      end
   end

endmodule

// File: rtl/imem_uart_loader.sv
// ---------------------------------------------------------------------------
// imem_uart_loader
// Boot loader: receives a program image over UART and writes it word by word
// into instruction memory while holding the processor in reset.
// Frame: A5, count lo, count hi, 4*N data bytes (little-endian words).
// Optional macro LOADER_CHECKSUM_EN: a trailing XOR-of-data byte is required
// and checked before the core is released.
// Ports:
//   clock      in  : sole clock, rising edge
//   reset_n    in  : asynchronous active-low reset
//   rx         in  : UART serial input, 8N1
//   insMemEn   out : one-cycle instruction-memory write strobe
//   insMemAddr out : word index being written
//   insMemData out : instruction word being written
//   cpuReset   out : processor reset, high except when the image is loaded
//   done       out : image loaded (level)
//   error      out : load aborted (level)
// ---------------------------------------------------------------------------
module imem_uart_loader
   import loader_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DEPTH        = 512
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             rx,
   output logic             insMemEn,
   output logic [WIDTH-1:0] insMemAddr,
   output logic [WIDTH-1:0] insMemData,
   output logic             cpuReset,
   output logic             done,
   output logic             error
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t           state, state_nxt;
   logic [7:0]       rx_byte;
   logic             byte_vld, frm_err;
   logic [7:0]       len_lo;
   logic [15:0]      word_cnt;
   logic [15:0]      n_now;
   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic [31:0]      word_buf;
   logic [7:0]       csum;
   logic             hdr, last_word;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clock    (clock),
      .reset_n  (reset_n),
      .rx       (rx),
      .rx_byte  (rx_byte),
      .byte_vld (byte_vld),
      .frm_err  (frm_err)
   );

   assign hdr       = byte_vld && (rx_byte == HDR_BYTE);
   assign n_now     = {rx_byte, len_lo};
   assign last_word = ((32'(idx) + 32'd1) == 32'(word_cnt));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (hdr) state_nxt = ST_LEN_LO;
         ST_LEN_LO: begin
            if (frm_err)       state_nxt = ST_ERROR;
            else if (byte_vld) state_nxt = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (frm_err) state_nxt = ST_ERROR;
            else if (byte_vld) begin
               if (n_now == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                  state_nxt = ST_CHECK;
`else
                  state_nxt = ST_DONE;
`endif
               else if (32'(n_now) > DEPTH) state_nxt = ST_ERROR;
               else                         state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (frm_err) state_nxt = ST_ERROR;
            else if (byte_vld && lane == 2'd3 && last_word)
`ifdef LOADER_CHECKSUM_EN
               state_nxt = ST_CHECK;
`else
               state_nxt = ST_DONE;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (frm_err)       state_nxt = ST_ERROR;
            else if (byte_vld) state_nxt = (rx_byte == csum) ? ST_DONE : ST_ERROR;
         end
`endif
         ST_DONE, ST_ERROR: if (hdr) state_nxt = ST_LEN_LO;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cpuReset = (state != ST_DONE);
      done     = (state == ST_DONE);
      error    = (state == ST_ERROR);
   end

   // write port and frame position: reset so a mid-frame reset drops the word
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         insMemEn   <= 1'b0;
         insMemAddr <= '0;
         insMemData <= '0;
         word_cnt   <= '0;
         idx        <= '0;
         lane       <= '0;
      end else begin
         insMemEn <= 1'b0;
         if (state == ST_LEN_HI && byte_vld) begin
            word_cnt <= n_now;
            idx      <= '0;
            lane     <= '0;
         end
         if (state == ST_DATA && byte_vld) begin
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
               insMemEn   <= 1'b1;
               insMemAddr <= WIDTH'(idx);
               insMemData <= WIDTH'({rx_byte, word_buf[23:0]});
               // stop at N-1 so the index never wraps
               if (!last_word) idx <= idx + 1'b1;
            end
         end
      end
   end

   // pure data: always written before it is consumed, so no reset needed
   always_ff @(posedge clock) begin
      if (state == ST_LEN_LO && byte_vld) len_lo <= rx_byte;
      if (state == ST_LEN_HI && byte_vld) csum <= 8'h00;
      if (state == ST_DATA && byte_vld) begin
         word_buf[8*lane +: 8] <= rx_byte;
         csum                  <= csum ^ rx_byte;
      end
   end

endmodule
